// File: rtl/line_data_memory.sv
// Byte-addressed line memory with a burst engine for line fills and
// writebacks, plus an independent direct-store port that can write a
// byte, halfword or word in any cycle.
module line_data_memory #(
    parameter int ADDR_WIDTH = 13,
    parameter int LINE_WORDS = 16,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [31:0]           rd_data,
    output logic                  rd_last,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [31:0]           wr_data,
    output logic                  wr_done,
    input  logic                  st_en,
    input  logic [1:0]            st_size,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [31:0]           st_data
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = BEAT_W + 2;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((1 << OFF_W) - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [3:0]            LAT_INIT  = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, FILL, WBACK} state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [3:0]              count_q, count_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic                    write_q, write_d;
    logic                    wr_done_q, wr_done_d;

    logic [7:0]              mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    wb_we;
    logic [ADDR_WIDTH-1:0]   st_base;
    logic [2:0]              st_nbytes;

    // The base keeps its line-offset bits at zero, so adding the beat
    // offset can never carry out of the line.
    assign word_addr = base_q + ADDR_WIDTH'({beat_q, 2'b00});
    assign wb_we     = (state_q == WBACK) && wr_valid;

    assign req_ready = (state_q == IDLE);
    assign rd_valid  = (state_q == FILL);
    assign rd_last   = (state_q == FILL) && (beat_q == LAST_BEAT);
    assign wr_ready  = (state_q == WBACK);
    assign wr_done   = wr_done_q;

    assign rd_data = {mem_q[word_addr + ADDR_WIDTH'(3)],
                      mem_q[word_addr + ADDR_WIDTH'(2)],
                      mem_q[word_addr + ADDR_WIDTH'(1)],
                      mem_q[word_addr]};

    // Align the direct-store address to its access size and work out how many bytes it writes.
    always_comb begin
        st_base   = st_addr;
        st_nbytes = 3'd0;
        case (st_size)
            2'b00: st_nbytes = 3'd1;
            2'b01: begin
                st_base   = st_addr & ~ADDR_WIDTH'(1);
                st_nbytes = 3'd2;
            end
            2'b10: begin
                st_base   = st_addr & ~ADDR_WIDTH'(3);
                st_nbytes = 3'd4;
            end
            default: st_nbytes = 3'd0;
        endcase
        if (!st_en) begin
            st_nbytes = 3'd0;
        end
    end

    // Byte array writes; the direct store is applied last so it overrides a colliding beat byte.
    always_ff @(posedge clk) begin
        if (wb_we) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[word_addr + ADDR_WIDTH'(k)] <= wr_data[8*k +: 8];
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < st_nbytes) begin
                mem_q[st_base + ADDR_WIDTH'(k)] <= st_data[8*k +: 8];
            end
        end
    end

    // Burst engine next-state logic: accept, wait out the latency, then stream beats.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        count_d   = count_q;
        base_d    = base_q;
        write_d   = write_q;
        wr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d  = req_addr & ~OFF_MASK;
                    beat_d  = '0;
                    count_d = LAT_INIT;
                    write_d = req_write;
                    if (LATENCY == 0) begin
                        state_d = req_write ? WBACK : FILL;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q <= 4'd1) begin
                    count_d = 4'd0;
                    state_d = write_q ? WBACK : FILL;
                end
            end
            FILL: begin
                if (rd_ready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            WBACK: begin
                if (wr_valid) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        beat_d    = '0;
                        wr_done_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Engine state registers; reset aborts any burst but leaves the array alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            count_q   <= '0;
            base_q    <= '0;
            write_q   <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            count_q   <= count_d;
            base_q    <= base_d;
            write_q   <= write_d;
            wr_done_q <= wr_done_d;
        end
    end

endmodule
